updown_sweep_ctrl: RTL and testbench

Sequencing controller for one external `counter_nbit_updown` instance. It drives the counter's `load`, `data`, `enable` and `up_down` pins to run a programmed triangular sweep: load a start value, count up to a high limit, pause, count down to a low limit, pause, and repeat for a set number of sweeps. It uses the counter's `count` output as feedback to stop exactly at each limit. It sits between a configuration/host interface and the counter datapath.

---
 rtl/updown_sweep_pkg.sv | 18 +
 rtl/updown_sweep_ctrl_pause_timer.sv | 35 +++
 rtl/updown_sweep_ctrl.sv | 153 +++++++++++++++
 tb/tb_updown_sweep_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/updown_sweep_pkg.sv
// Shared types and constants for the up/down sweep controller.
//   sweep_state_t : controller state encoding
//   N_SWEEP_BITS  : width of the sweep count and sweep counter
package updown_sweep_pkg;

    localparam int N_SWEEP_BITS = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_UP       = 3'd2,
        ST_PAUSE_HI = 3'd3,
        ST_DOWN     = 3'd4,
        ST_PAUSE_LO = 3'd5,
        ST_DONE     = 3'd6
    } sweep_state_t;

endpackage

// File: rtl/updown_sweep_ctrl_pause_timer.sv
// Pause timer shared by both turn-around pauses.
// A loadable down-counter: after a load pulse, 'expired' goes high in the
// PAUSE_CYCLES-th cycle, so a state that loads it on entry and leaves on
// 'expired' lasts exactly PAUSE_CYCLES cycles.
//   clk     : system clock
//   reset   : synchronous, active-high
//   load    : restart the pause (asserted on the edge entering a pause)
//   expired : remaining count has reached zero
module sweep_pause_timer #(
    parameter int PAUSE_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expired
);

    localparam int CW = (PAUSE_CYCLES < 2) ? 1 : $clog2(PAUSE_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(PAUSE_CYCLES - 1);

    logic [CW-1:0] remaining;

    always_ff @(posedge clk) begin
        if (reset) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= RELOAD;
        end else if (remaining != '0) begin
            remaining <= remaining - CW'(1);
        end
    end

    assign expired = (remaining == '0);

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangular sweep sequencer for an external up/down counter.
// Loads start_val, counts up to hi_lim, pauses, counts down to lo_lim,
// pauses, and repeats for n_sweeps sweeps (0 = until abort). The counter's
// registered count is fed back on count_in so each limit is hit exactly.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, abort        : run request (IDLE only) / unconditional stop
//   start_val, lo_lim,
//   hi_lim, n_sweeps    : run configuration, latched on an accepted start
//   count_in            : counter count feedback
//   ctr_load, ctr_data,
//   ctr_enable,
//   ctr_up_down         : counter control pins
//   busy, done, cfg_err : status (done / cfg_err are one-cycle pulses)
//   sweep_cnt           : completed sweeps in the current run
//
// state       | meaning
// ------------+----------------------------------------------
// ST_IDLE     | waiting for start
// ST_LOAD     | counter loaded with start_val
// ST_UP       | counting up until count_in == hi_lim
// ST_PAUSE_HI | holding at hi_lim for PAUSE_CYCLES
// ST_DOWN     | counting down until count_in == lo_lim
// ST_PAUSE_LO | holding at lo_lim for PAUSE_CYCLES
// ST_DONE     | final sweep finished, done pulse
module updown_sweep_ctrl
    import updown_sweep_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int PAUSE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [WIDTH-1:0]        start_val,
    input  logic [WIDTH-1:0]        lo_lim,
    input  logic [WIDTH-1:0]        hi_lim,
    input  logic [N_SWEEP_BITS-1:0] n_sweeps,
    input  logic [WIDTH-1:0]        count_in,
    output logic                    ctr_load,
    output logic [WIDTH-1:0]        ctr_data,
    output logic                    ctr_enable,
    output logic                    ctr_up_down,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err,
    output logic [N_SWEEP_BITS-1:0] sweep_cnt
);

    sweep_state_t state, next_state;

    logic [WIDTH-1:0]        lo_q, hi_q;
    logic [N_SWEEP_BITS-1:0] n_q;
    logic                    cfg_ok, accept, reject;
    logic                    at_hi, at_lo, last_sweep;
    logic [N_SWEEP_BITS-1:0] cnt_next;
    logic                    pause_load, pause_expired;

    assign cfg_ok = (lo_lim < hi_lim) && (start_val >= lo_lim) && (start_val <= hi_lim);
    assign accept = (state == ST_IDLE) && start && !abort && cfg_ok;
    assign reject = (state == ST_IDLE) && start && !abort && !cfg_ok;

    assign at_hi      = (count_in == hi_q);
    assign at_lo      = (count_in == lo_q);
    assign cnt_next   = sweep_cnt + N_SWEEP_BITS'(1);
    assign last_sweep = (n_q != '0) && (cnt_next == n_q);

    // Timer restarts on the edge that enters either pause state.
    assign pause_load = ((next_state == ST_PAUSE_HI) && (state != ST_PAUSE_HI)) ||
                        ((next_state == ST_PAUSE_LO) && (state != ST_PAUSE_LO));

    sweep_pause_timer #(
        .PAUSE_CYCLES(PAUSE_CYCLES)
    ) u_pause_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (pause_load),
        .expired(pause_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (accept) next_state = ST_LOAD;
                ST_LOAD:     next_state = ST_UP;
                ST_UP:       if (at_hi) next_state = ST_PAUSE_HI;
                ST_PAUSE_HI: if (pause_expired) next_state = ST_DOWN;
                ST_DOWN:     if (at_lo) next_state = last_sweep ? ST_DONE : ST_PAUSE_LO;
                ST_PAUSE_LO: if (pause_expired) next_state = ST_UP;
                ST_DONE:     next_state = ST_IDLE;
                default:     next_state = ST_IDLE;
            endcase
        end
    end

    // count_in comes from the counter's register, so ctr_enable closes no loop.
    always_comb begin
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
        ctr_load   = (state == ST_LOAD);
        ctr_enable = 1'b0;
        if (state == ST_UP) begin
            ctr_enable = !at_hi;
        end else if (state == ST_DOWN) begin
            ctr_enable = !at_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctr_data    <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            n_q         <= '0;
            sweep_cnt   <= '0;
            ctr_up_down <= 1'b1;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= reject;
            if (accept) begin
                ctr_data  <= start_val;
                lo_q      <= lo_lim;
                hi_q      <= hi_lim;
                n_q       <= n_sweeps;
                sweep_cnt <= '0;
            end
            // An abort coinciding with the low-limit hit does not count the sweep.
            if ((state == ST_DOWN) && at_lo && !abort) begin
                sweep_cnt <= cnt_next;
            end
            // Direction is set on entry to a counting state and held elsewhere.
            if (next_state == ST_UP) begin
                ctr_up_down <= 1'b1;
            end else if (next_state == ST_DOWN) begin
                ctr_up_down <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
module tb_updown_sweep_ctrl;

    localparam int WIDTH = 3;
    localparam int PAUSE = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] start_val = '0;
    logic [WIDTH-1:0] lo_lim = '0;
    logic [WIDTH-1:0] hi_lim = '0;
    logic [3:0]       n_sweeps = '0;
    logic [WIDTH-1:0] count = '0;

    logic             ctr_load;
    logic [WIDTH-1:0] ctr_data;
    logic             ctr_enable;
    logic             ctr_up_down;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic [3:0]       sweep_cnt;

    always #5 clk = ~clk;

    updown_sweep_ctrl #(
        .WIDTH       (WIDTH),
        .PAUSE_CYCLES(PAUSE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .start_val  (start_val),
        .lo_lim     (lo_lim),
        .hi_lim     (hi_lim),
        .n_sweeps   (n_sweeps),
        .count_in   (count),
        .ctr_load   (ctr_load),
        .ctr_data   (ctr_data),
        .ctr_enable (ctr_enable),
        .ctr_up_down(ctr_up_down),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .sweep_cnt  (sweep_cnt)
    );

    // Attached up/down counter (no reset: its value survives controller reset).
    always @(posedge clk) begin
        if (ctr_load) count <= ctr_data;
        else if (ctr_enable) count <= ctr_up_down ? count + 3'd1 : count - 3'd1;
    end

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        bit               is_done;
        int               cyc;
        int               scnt;
        int               cnt;
        int               data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cur_lo = 0;
    int  cur_hi = 7;
    bit  in_run = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops an expected event whenever done or cfg_err pulses,
    // and watches that the counter stays inside the limits during a run.
    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk);
            if (busy && in_run) begin
                chk("limit_low", int'(count < WIDTH'(cur_lo)), 0);
                chk("limit_high", int'(count > WIDTH'(cur_hi)), 0);
            end
            if (ctr_load) in_run = 1'b1;
            if (!busy) in_run = 1'b0;
            if (done || cfg_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", int'(done), 0);
                    chk("unexpected_cfg_err", int'(cfg_err), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_is_done", int'(done), int'(e.is_done));
                    chk("event_is_cfg_err", int'(cfg_err), int'(!e.is_done));
                    chk("event_cycle", edge_n, e.cyc);
                    if (e.is_done) begin
                        chk("done_sweep_cnt", int'(sweep_cnt), e.scnt);
                        chk("done_count", int'(count), e.cnt);
                        chk("done_ctr_data", int'(ctr_data), e.data);
                    end
                end
            end
        end
    endtask

    // Reference: phase lengths from the sweep rules, in cycles after the start edge.
    task automatic do_start(input int sv, input int lo, input int hi, input int n,
                            input bit track, output int e0);
        ev_t e;
        int  d;
        @(negedge clk);
        start_val = WIDTH'(sv);
        lo_lim    = WIDTH'(lo);
        hi_lim    = WIDTH'(hi);
        n_sweeps  = 4'(n);
        start     = 1'b1;
        cur_lo    = lo;
        cur_hi    = hi;
        e0        = edge_n;
        if (track) begin
            if (lo < hi && sv >= lo && sv <= hi) begin
                d         = hi - lo + 1;
                e.is_done = 1'b1;
                e.cyc     = e0 + 2 + (hi - sv + 1) + PAUSE + d + (n - 1) * (2 * PAUSE + 2 * d);
                e.scnt    = n;
                e.cnt     = lo;
                e.data    = sv;
            end else begin
                e.is_done = 1'b0;
                e.cyc     = e0 + 1;
                e.scnt    = 0;
                e.cnt     = 0;
                e.data    = 0;
            end
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle"}, int'(busy), 0);
    endtask

    task automatic drain(input string name);
        repeat (2) @(negedge clk);
        chk({name, "_pending_events"}, exp_q.size(), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctr_load"}, int'(ctr_load), 0);
        chk({tag, "_ctr_enable"}, int'(ctr_enable), 0);
        chk({tag, "_ctr_up_down"}, int'(ctr_up_down), 1);
        chk({tag, "_ctr_data"}, int'(ctr_data), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_cfg_err"}, int'(cfg_err), 0);
        chk({tag, "_sweep_cnt"}, int'(sweep_cnt), 0);
    endtask

    task automatic wait_cond_cnt(input string name, input int target, input int budget);
        int n = 0;
        while (int'(sweep_cnt) != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(sweep_cnt), target);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int n;
        int scnt;
        int lo, hi, sv, ns;

        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;

        // Basic run: 2 -> 5 -> 1 -> 5 -> 1, done in cycle 27, idle from 28.
        do_start(2, 1, 5, 2, 1'b1, e0);
        wait_idle("basic", 60);
        chk("basic_idle_cycle", edge_n, e0 + 28);
        chk("basic_sweep_cnt_hold", int'(sweep_cnt), 2);
        drain("basic");

        // Config error: lo == hi.
        do_start(2, 4, 4, 1, 1'b1, e0);
        for (int i = 0; i < 3; i++) begin
            chk("cfgerr_busy", int'(busy), 0);
            chk("cfgerr_ctr_load", int'(ctr_load), 0);
            @(negedge clk);
        end
        drain("cfgerr");

        // Abort during DOWN at count 3 (enable active, so counter lands on 2).
        do_start(2, 1, 6, 3, 1'b0, e0);
        n = 0;
        while (!(busy && ctr_enable && !ctr_up_down && count == 3'd3) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach_down3", int'(count), 3);
        scnt  = int'(sweep_cnt);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_enable", int'(ctr_enable), 0);
        chk("abort_count", int'(count), 2);
        chk("abort_sweep_cnt", int'(sweep_cnt), scnt);
        chk("abort_done", int'(done), 0);
        @(negedge clk);
        chk("abort_count_frozen", int'(count), 2);
        drain("abort");

        // Start at hi limit, free-running with n_sweeps = 0.
        do_start(7, 5, 7, 0, 1'b0, e0);
        n = 0;
        while (!ctr_load && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("limit_start_load", int'(ctr_load), 1);
        @(negedge clk);
        chk("limit_up_enable", int'(ctr_enable), 0);
        chk("limit_up_count", int'(count), 7);
        chk("limit_up_dir", int'(ctr_up_down), 1);
        repeat (2) @(negedge clk);
        chk("limit_pause_dir", int'(ctr_up_down), 1);
        @(negedge clk);
        chk("limit_down_dir", int'(ctr_up_down), 0);
        chk("limit_down_enable", int'(ctr_enable), 1);
        wait_cond_cnt("freerun_reach15", 15, 400);
        wait_cond_cnt("freerun_wrap0", 0, 40);
        wait_cond_cnt("freerun_wrap1", 1, 40);
        chk("freerun_busy", int'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("freerun_abort_busy", int'(busy), 0);
        chk("freerun_abort_cnt", int'(sweep_cnt), 1);
        drain("freerun");

        // Reset in the middle of UP, then a normal run.
        do_start(1, 0, 6, 1, 1'b0, e0);
        n = 0;
        while (!(busy && ctr_enable && ctr_up_down) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midup_reached", int'(ctr_enable && ctr_up_down), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("midup_reset");
        do_start(0, 0, 3, 1, 1'b1, e0);
        wait_idle("after_reset", 60);
        drain("after_reset");

        // Randomized runs, with config inputs scrambled while busy.
        for (int it = 0; it < 14; it++) begin
            if ($urandom_range(0, 3) != 0) begin
                lo = int'($urandom_range(0, 5));
                hi = int'($urandom_range(lo + 1, 7));
                sv = int'($urandom_range(lo, hi));
            end else begin
                lo = int'($urandom_range(0, 7));
                hi = int'($urandom_range(0, 7));
                sv = int'($urandom_range(0, 7));
            end
            ns = int'($urandom_range(1, 3));
            do_start(sv, lo, hi, ns, 1'b1, e0);
            start_val = WIDTH'($urandom_range(0, 7));
            lo_lim    = WIDTH'($urandom_range(0, 7));
            hi_lim    = WIDTH'($urandom_range(0, 7));
            n_sweeps  = 4'($urandom_range(0, 15));
            wait_idle("random", 200);
            drain("random");
        end

        chk("final_pending_events", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
